// File: rtl/ula_pkg.sv
// Shared definitions for the ULA front-end: state encoding and default widths.
package ula_pkg;

   localparam int LARGURA_PAD    = 8;
   localparam int LARGURA_OP_PAD = 3;

   // Entry sequence states; the encoding is visible on the estado port.
   typedef enum logic [1:0] {
      ESPERA_A  = 2'b00,
      ESPERA_B  = 2'b01,
      ESPERA_OP = 2'b10,
      EXECUTA   = 2'b11
   } estado_t;

endpackage

// File: rtl/filtro_botao.sv
// Front-panel button conditioner: 2-flop synchroniser, stability counter and
// rising-edge detector. pulso_pressao is a registered one-cycle pulse on every
// accepted 0->1 change of the debounced level; releases produce nothing.
module filtro_botao #(
   parameter int DEBOUNCE_CICLOS = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic botao_bruto,
   output logic pulso_pressao
);

   localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
   localparam logic [CW-1:0] CONT_MAX = CW'(DEBOUNCE_CICLOS - 1);

   logic          sinc1, sinc2;
   logic          nivel;
   logic [CW-1:0] cont;

   // Bring the raw asynchronous button into the clock domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sinc1 <= 1'b0;
         sinc2 <= 1'b0;
      end else begin
         sinc1 <= botao_bruto;
         sinc2 <= sinc1;
      end
   end

   // Flip the level after DEBOUNCE_CICLOS consecutive differing samples; any agreement restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nivel         <= 1'b0;
         cont          <= '0;
         pulso_pressao <= 1'b0;
      end else begin
         pulso_pressao <= 1'b0;
         if (sinc2 != nivel) begin
            if (cont == CONT_MAX) begin
               nivel         <= sinc2;
               cont          <= '0;
               pulso_pressao <= sinc2;
            end else begin
               cont <= cont + 1'b1;
            end
         end else begin
            cont <= '0;
         end
      end
   end

endmodule

// File: rtl/sequenciador_entrada.sv
// Entry sequencer between board switches/button and the ULA datapath.
// Latches A, B and the opcode on successive button presses, fires a one-cycle
// executar strobe and holds results until the ULA acknowledges with ula_pronto.
// Optional macro VALIDA_OPERACAO_EN: reject opcodes >= NUM_OPERACOES with a
// one-cycle erro_op pulse instead of starting execution.
module sequenciador_entrada
   import ula_pkg::*;
#(
   parameter int LARGURA         = LARGURA_PAD,
   parameter int LARGURA_OP      = LARGURA_OP_PAD,
   parameter int DEBOUNCE_CICLOS = 4,
   parameter int NUM_OPERACOES   = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [LARGURA-1:0]    entrada_numero,
   input  logic [LARGURA_OP-1:0] operacao,
   input  logic                  entrada_botao,
   input  logic                  cancelar,
   input  logic                  ula_pronto,
   output logic [LARGURA-1:0]    operando_a,
   output logic [LARGURA-1:0]    operando_b,
   output logic [LARGURA_OP-1:0] codigo_op,
   output logic                  executar,
   output logic [1:0]            estado,
   output logic                  ocupado,
   output logic                  resultado_valido,
   output logic                  erro_op
);

`ifdef VALIDA_OPERACAO_EN
   localparam logic VALIDA = 1'b1;
`else
   localparam logic VALIDA = 1'b0;
`endif

   // One extra bit so a limit of 2**LARGURA_OP still fits.
   localparam logic [LARGURA_OP:0] OP_LIMITE = NUM_OPERACOES[LARGURA_OP:0];

   estado_t st;
   logic    pressao;
   logic    op_invalida;

   filtro_botao #(
      .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
   ) u_filtro (
      .clk          (clk),
      .rst_n        (rst_n),
      .botao_bruto  (entrada_botao),
      .pulso_pressao(pressao)
   );

   // Constant 0 when validation is compiled out, so erro_op never rises.
   assign op_invalida = VALIDA && ({1'b0, operacao} >= OP_LIMITE);
   assign estado      = st;

   // Entry FSM with registered outputs; cancelar overrides presses and ula_pronto.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st               <= ESPERA_A;
         operando_a       <= '0;
         operando_b       <= '0;
         codigo_op        <= '0;
         executar         <= 1'b0;
         ocupado          <= 1'b0;
         resultado_valido <= 1'b0;
         erro_op          <= 1'b0;
      end else begin
         executar <= 1'b0;
         erro_op  <= 1'b0;
         if (cancelar) begin
            st               <= ESPERA_A;
            ocupado          <= 1'b0;
            resultado_valido <= 1'b0;
         end else begin
            case (st)
               ESPERA_A: if (pressao) begin
                  operando_a <= entrada_numero;
                  st         <= ESPERA_B;
               end
               ESPERA_B: if (pressao) begin
                  operando_b <= entrada_numero;
                  st         <= ESPERA_OP;
               end
               ESPERA_OP: if (pressao) begin
                  if (op_invalida) begin
                     erro_op <= 1'b1;
                  end else begin
                     codigo_op <= operacao;
                     st        <= EXECUTA;
                     executar  <= 1'b1;
                     ocupado   <= 1'b1;
                  end
               end
               EXECUTA: begin
                  // Presses are dropped while busy; ula_pronto only matters while busy.
                  if (ocupado) begin
                     if (ula_pronto) begin
                        ocupado          <= 1'b0;
                        resultado_valido <= 1'b1;
                     end
                  end else if (pressao && resultado_valido) begin
                     st               <= ESPERA_A;
                     resultado_valido <= 1'b0;
                  end
               end
               default: st <= ESPERA_A;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sequenciador_entrada.sv
// Self-checking bench for sequenciador_entrada: directed table of press
// actions, hand-written corner sequences, then randomized stimulus compared
// cycle by cycle against an event-level reference model.
module tb_sequenciador_entrada;

   localparam int D = 4;
   localparam int NOPS = 6;
`ifdef VALIDA_OPERACAO_EN
   localparam bit VAL = 1'b1;
`else
   localparam bit VAL = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] num = '0;
   logic [2:0] oper = '0;
   logic       botao = 1'b0;
   logic       cancelar = 1'b0;
   logic       pronto = 1'b0;
   logic [7:0] op_a, op_b;
   logic [2:0] cod;
   logic       executar, ocupado, rv, erro_op;
   logic [1:0] estado;

   int tests = 0;
   int fails = 0;
   int exe_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   sequenciador_entrada #(
      .LARGURA(8), .LARGURA_OP(3), .DEBOUNCE_CICLOS(D), .NUM_OPERACOES(NOPS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .entrada_numero(num), .operacao(oper),
      .entrada_botao(botao), .cancelar(cancelar), .ula_pronto(pronto),
      .operando_a(op_a), .operando_b(op_b), .codigo_op(cod),
      .executar(executar), .estado(estado), .ocupado(ocupado),
      .resultado_valido(rv), .erro_op(erro_op)
   );

   // Pulse counters for strobe-width checks.
   always @(negedge clk) begin
      if (executar) exe_cnt++;
      if (erro_op) err_cnt++;
   end

   // ---------------- reference model ----------------
   // Button: raw delayed two samples; level flips once the last D samples all
   // disagree with it. FSM: step 0..3 advanced by press events.
   bit       m_s1, m_s2, m_deb, m_press, p_old, todos;
   bit       hist[$];
   int       m_step;
   bit [7:0] m_a, m_b;
   bit [2:0] m_op;
   bit       m_exe, m_ocup, m_rv, m_err;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 = 0; m_s2 = 0; m_deb = 0; m_press = 0; hist = {};
         m_step = 0; m_a = 0; m_b = 0; m_op = 0;
         m_exe = 0; m_ocup = 0; m_rv = 0; m_err = 0;
      end else begin
         p_old = m_press;
         m_exe = 0; m_err = 0;
         if (cancelar) begin
            m_step = 0; m_ocup = 0; m_rv = 0;
         end else if (m_step == 0 && p_old) begin
            m_a = num; m_step = 1;
         end else if (m_step == 1 && p_old) begin
            m_b = num; m_step = 2;
         end else if (m_step == 2 && p_old) begin
            if (VAL && int'(oper) >= NOPS) m_err = 1;
            else begin m_op = oper; m_step = 3; m_exe = 1; m_ocup = 1; end
         end else if (m_step == 3) begin
            if (m_ocup) begin
               if (pronto) begin m_ocup = 0; m_rv = 1; end
            end else if (p_old && m_rv) begin
               m_step = 0; m_rv = 0;
            end
         end
         hist.push_back(m_s2);
         if (hist.size() > D) void'(hist.pop_front());
         m_press = 0;
         if (hist.size() == D) begin
            todos = 1;
            foreach (hist[i]) if (hist[i] == m_deb) todos = 0;
            if (todos) begin m_deb = ~m_deb; m_press = m_deb; end
         end
         m_s2 = m_s1; m_s1 = botao;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_reset(input string nm);
      chk(nm, {estado, op_a, op_b, cod, executar, ocupado, rv, erro_op}, 32'd0);
   endtask

   task automatic aplica_reset();
      @(negedge clk);
      rst_n = 0; botao = 0; cancelar = 0; pronto = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   task automatic pressiona(input logic [7:0] n, input logic [2:0] o);
      num = n; oper = o; botao = 1;
      repeat (8) @(negedge clk);
      botao = 0;
      repeat (8) @(negedge clk);
   endtask

   typedef enum int {A_PRESS, A_PRONTO, A_CANCEL, A_CANCEL_PRESS} acao_t;
   typedef struct {
      acao_t      acao;
      logic [7:0] n;
      logic [2:0] o;
      logic [1:0] e_st;
      logic [7:0] e_a, e_b;
      logic [2:0] e_op;
      logic       e_ocup, e_rv;
      int         e_exe;
   } vetor_t;

   vetor_t tab[12];

   initial begin
      tab[0]  = '{A_PRESS,        8'h05, 3'd0, 2'd1, 8'h05, 8'h00, 3'd0, 1'b0, 1'b0, 0};
      tab[1]  = '{A_PRESS,        8'h03, 3'd0, 2'd2, 8'h05, 8'h03, 3'd0, 1'b0, 1'b0, 0};
      tab[2]  = '{A_PRESS,        8'h00, 3'd2, 2'd3, 8'h05, 8'h03, 3'd2, 1'b1, 1'b0, 1};
      tab[3]  = '{A_PRESS,        8'h77, 3'd5, 2'd3, 8'h05, 8'h03, 3'd2, 1'b1, 1'b0, 0};
      tab[4]  = '{A_PRONTO,       8'h00, 3'd0, 2'd3, 8'h05, 8'h03, 3'd2, 1'b0, 1'b1, 0};
      tab[5]  = '{A_PRESS,        8'h99, 3'd0, 2'd0, 8'h05, 8'h03, 3'd2, 1'b0, 1'b0, 0};
      tab[6]  = '{A_PRESS,        8'h11, 3'd0, 2'd1, 8'h11, 8'h03, 3'd2, 1'b0, 1'b0, 0};
      tab[7]  = '{A_CANCEL_PRESS, 8'h22, 3'd0, 2'd0, 8'h11, 8'h03, 3'd2, 1'b0, 1'b0, 0};
      tab[8]  = '{A_PRESS,        8'hAA, 3'd0, 2'd1, 8'hAA, 8'h03, 3'd2, 1'b0, 1'b0, 0};
      tab[9]  = '{A_PRESS,        8'hBB, 3'd0, 2'd2, 8'hAA, 8'hBB, 3'd2, 1'b0, 1'b0, 0};
      tab[10] = '{A_CANCEL,       8'h00, 3'd0, 2'd0, 8'hAA, 8'hBB, 3'd2, 1'b0, 1'b0, 0};
      tab[11] = '{A_PRESS,        8'hCC, 3'd0, 2'd1, 8'hCC, 8'hBB, 3'd2, 1'b0, 1'b0, 0};

      // Reset values
      #2;
      chk_reset("reset_inicial");
      aplica_reset();

      // Press latency: latch on edge D+3, then no second latch while held
      @(negedge clk); botao = 1; num = 8'h3C;
      repeat (D + 2) @(negedge clk);
      chk("lat_antes_estado", estado, 2'd0);
      chk("lat_antes_a", op_a, 8'h00);
      @(negedge clk);
      chk("lat_estado", estado, 2'd1);
      chk("lat_a", op_a, 8'h3C);
      num = 8'h55;
      repeat (3) @(negedge clk);
      botao = 0;
      repeat (8) @(negedge clk);
      chk("lat_unico_estado", estado, 2'd1);
      chk("lat_unico_a", op_a, 8'h3C);

      // Table-driven sequence
      aplica_reset();
      @(negedge clk);
      foreach (tab[k]) begin
         exe_cnt = 0;
         case (tab[k].acao)
            A_PRESS: pressiona(tab[k].n, tab[k].o);
            A_PRONTO: begin
               repeat (5) @(negedge clk);
               pronto = 1; @(negedge clk); pronto = 0;
               repeat (2) @(negedge clk);
            end
            A_CANCEL: begin
               cancelar = 1; @(negedge clk); cancelar = 0;
               repeat (2) @(negedge clk);
            end
            A_CANCEL_PRESS: begin
               cancelar = 1;
               pressiona(tab[k].n, tab[k].o);
               cancelar = 0;
               repeat (2) @(negedge clk);
            end
            default: ;
         endcase
         chk($sformatf("tab%0d_estado", k), estado, tab[k].e_st);
         chk($sformatf("tab%0d_a", k), op_a, tab[k].e_a);
         chk($sformatf("tab%0d_b", k), op_b, tab[k].e_b);
         chk($sformatf("tab%0d_op", k), cod, tab[k].e_op);
         chk($sformatf("tab%0d_ocupado", k), ocupado, tab[k].e_ocup);
         chk($sformatf("tab%0d_rv", k), rv, tab[k].e_rv);
         chk($sformatf("tab%0d_executar", k), exe_cnt, tab[k].e_exe);
      end

      // Glitch: 3 high, 1 low, 3 high never reaches D stable samples
      num = 8'hEE;
      botao = 1; repeat (3) @(negedge clk);
      botao = 0; @(negedge clk);
      botao = 1; repeat (3) @(negedge clk);
      botao = 0; repeat (10) @(negedge clk);
      chk("glitch_estado", estado, 2'd1);
      chk("glitch_a", op_a, 8'hCC);

      // Async reset mid-debounce
      @(negedge clk); botao = 1; num = 8'h10;
      repeat (3) @(negedge clk);
      #2 rst_n = 0;
      #1 chk_reset("rst_debounce");
      @(negedge clk); botao = 0; rst_n = 1;
      // Async reset in EXECUTA
      pressiona(8'h01, 3'd0);
      pressiona(8'h02, 3'd0);
      pressiona(8'h00, 3'd4);
      chk("rst_pre_estado", estado, 2'd3);
      #2 rst_n = 0;
      #1 chk_reset("rst_executa");
      @(negedge clk); rst_n = 1;
      pressiona(8'h42, 3'd0);
      chk("pos_rst_estado", estado, 2'd1);
      chk("pos_rst_a", op_a, 8'h42);

`ifdef VALIDA_OPERACAO_EN
      aplica_reset();
      @(negedge clk);
      pressiona(8'h01, 3'd0);
      pressiona(8'h02, 3'd0);
      exe_cnt = 0; err_cnt = 0;
      pressiona(8'h00, 3'd7);
      chk("opinv_estado", estado, 2'd2);
      chk("opinv_codigo", cod, 3'd0);
      chk("opinv_erro", err_cnt, 1);
      chk("opinv_executar", exe_cnt, 0);
      exe_cnt = 0;
      pressiona(8'h00, 3'd1);
      chk("opval_estado", estado, 2'd3);
      chk("opval_codigo", cod, 3'd1);
      chk("opval_executar", exe_cnt, 1);
`endif

      // Randomized stimulus against the model
      aplica_reset();
      for (int s = 0; s < 200; s++) begin
         botao = 1'($urandom_range(0, 1));
         for (int c = 0, len = $urandom_range(1, 12); c < len; c++) begin
            num = 8'($urandom);
            oper = 3'($urandom);
            pronto = ($urandom_range(0, 5) == 0);
            cancelar = ($urandom_range(0, 60) == 0);
            @(negedge clk);
            chk("aleatorio",
                {estado, op_a, op_b, cod, executar, ocupado, rv, erro_op},
                {m_step[1:0], m_a, m_b, m_op, m_exe, m_ocup, m_rv, m_err});
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
